exc_commit_ctrl: RTL and testbench

- Exception/interrupt commit controller between the WB stage and the CSR unit.
- Prioritises WB-stage exception flags and pending interrupts, and drives the CSR unit's wb_ex, wb_ecode, wb_esubcode, WB_pc, wb_badvaddr and ertn_flush inputs.
- Sequences pipeline flush and an IF redirect handshake to the trap entry (ex_entry) or the return address (ex_exit), then drains before accepting new commits.

---
 rtl/exc_commit_ctrl_pkg.sv | 36 +++
 rtl/exc_commit_ctrl_if.sv | 40 ++++
 rtl/exc_commit_ctrl_prio_enc.sv | 53 +++++
 rtl/exc_commit_ctrl.sv | 129 ++++++++++++
 tb/tb_exc_commit_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the exception commit controller: exception codes,
// flag bit positions within wb_exc_flags, FSM state and event encodings.
package exc_commit_ctrl_pkg;

  // Exception codes presented to the CSR unit
  localparam logic [5:0] EXC_ECODE_INT = 6'h00;
  localparam logic [5:0] EXC_ECODE_ADE = 6'h08;
  localparam logic [5:0] EXC_ECODE_ALE = 6'h09;
  localparam logic [5:0] EXC_ECODE_SYS = 6'h0B;
  localparam logic [5:0] EXC_ECODE_BRK = 6'h0C;
  localparam logic [5:0] EXC_ECODE_INE = 6'h0D;

  localparam logic [8:0] EXC_ESUBCODE_ADEF = 9'h000;

  // Bit positions inside wb_exc_flags = {adef, ine, sys, brk, ale}
  localparam int FLAG_ADEF = 4;
  localparam int FLAG_INE  = 3;
  localparam int FLAG_SYS  = 2;
  localparam int FLAG_BRK  = 1;
  localparam int FLAG_ALE  = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  // Kind of event found at commit; interrupts count as exceptions
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_ERTN = 2'd2
  } ev_kind_e;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// WB / CSR / IF-redirect signal bundle around the exception commit controller.
// master = the controller, slave = the pipeline and CSR unit around it.
interface exc_commit_ctrl_if #(
  parameter int PC_W = 32
);
  logic            wb_valid;
  logic            wb_ready;
  logic [PC_W-1:0] wb_pc_in;
  logic [PC_W-1:0] wb_vaddr_in;
  logic [4:0]      wb_exc_flags;
  logic            wb_is_ertn;
  logic            csr_has_int;
  logic [PC_W-1:0] ex_entry;
  logic [PC_W-1:0] ex_exit;
  logic            wb_suppress;
  logic            wb_ex;
  logic [5:0]      wb_ecode;
  logic [8:0]      wb_esubcode;
  logic [PC_W-1:0] WB_pc;
  logic [PC_W-1:0] wb_badvaddr;
  logic            ertn_flush;
  logic            flush;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    input  wb_valid, wb_pc_in, wb_vaddr_in, wb_exc_flags, wb_is_ertn,
           csr_has_int, ex_entry, ex_exit, redirect_ready,
    output wb_ready, wb_suppress, wb_ex, wb_ecode, wb_esubcode, WB_pc,
           wb_badvaddr, ertn_flush, flush, redirect_valid, redirect_pc
  );

  modport slave (
    output wb_valid, wb_pc_in, wb_vaddr_in, wb_exc_flags, wb_is_ertn,
           csr_has_int, ex_entry, ex_exit, redirect_ready,
    input  wb_ready, wb_suppress, wb_ex, wb_ecode, wb_esubcode, WB_pc,
           wb_badvaddr, ertn_flush, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Combinational priority encoder: picks the single event reported for the
// WB instruction (INT > ADEF > INE > SYS > BRK > ALE > ERTN) and its fields.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [4:0]      flags,
  input  logic            has_int,
  input  logic            is_ertn,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] vaddr,
  output ev_kind_e        ev_kind,
  output logic [5:0]      ecode,
  output logic [8:0]      esubcode,
  output logic [PC_W-1:0] badvaddr
);

  // Priority chain; an exception always masks a simultaneous ertn
  always_comb begin
    ev_kind  = EV_NONE;
    ecode    = 6'h00;
    esubcode = 9'h000;
    badvaddr = '0;
    if (has_int) begin
      ev_kind = EV_EXC;
      ecode   = EXC_ECODE_INT;
    end else if (flags[FLAG_ADEF]) begin
      ev_kind  = EV_EXC;
      ecode    = EXC_ECODE_ADE;
      esubcode = EXC_ESUBCODE_ADEF;
      badvaddr = pc;
    end else if (flags[FLAG_INE]) begin
      ev_kind = EV_EXC;
      ecode   = EXC_ECODE_INE;
    end else if (flags[FLAG_SYS]) begin
      ev_kind = EV_EXC;
      ecode   = EXC_ECODE_SYS;
    end else if (flags[FLAG_BRK]) begin
      ev_kind = EV_EXC;
      ecode   = EXC_ECODE_BRK;
    end else if (flags[FLAG_ALE]) begin
      ev_kind  = EV_EXC;
      ecode    = EXC_ECODE_ALE;
      badvaddr = vaddr;
    end else if (is_ertn) begin
      ev_kind = EV_ERTN;
    end else begin
      ev_kind = EV_NONE;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller between WB and the CSR unit.
// Latches the winning event at commit, pulses wb_ex or ertn_flush for one
// cycle, redirects IF to the trap entry or ERA, then drains the pipeline.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input logic               clk,
  input logic               resetn,
  exc_commit_ctrl_if.master bus
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  ev_kind_e        ev_kind_s;
  logic [5:0]      ev_ecode_s;
  logic [8:0]      ev_esubcode_s;
  logic [PC_W-1:0] ev_badvaddr_s;
  logic            commit_s;

  state_e          state_r;
  logic [3:0]      cnt_r;
  logic            wb_ready_r;
  logic            wb_ex_r;
  logic            ertn_flush_r;
  logic            flush_r;
  logic            redirect_valid_r;
  logic            is_ertn_r;
  logic [5:0]      ecode_r;
  logic [8:0]      esubcode_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] badvaddr_r;

  exc_prio_enc #(.PC_W(PC_W)) u_prio (
    .flags    (bus.wb_exc_flags),
    .has_int  (bus.csr_has_int),
    .is_ertn  (bus.wb_is_ertn),
    .pc       (bus.wb_pc_in),
    .vaddr    (bus.wb_vaddr_in),
    .ev_kind  (ev_kind_s),
    .ecode    (ev_ecode_s),
    .esubcode (ev_esubcode_s),
    .badvaddr (ev_badvaddr_s)
  );

  // wb_ready is only high in IDLE, so csr_has_int is ignored elsewhere
  assign commit_s = bus.wb_valid && wb_ready_r;

  // Commit FSM with registered handshake, pulse and field outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 4'd0;
      wb_ready_r       <= 1'b1;
      wb_ex_r          <= 1'b0;
      ertn_flush_r     <= 1'b0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      is_ertn_r        <= 1'b0;
      ecode_r          <= 6'h00;
      esubcode_r       <= 9'h000;
      pc_r             <= '0;
      badvaddr_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (commit_s && (ev_kind_s != EV_NONE)) begin
            ecode_r      <= ev_ecode_s;
            esubcode_r   <= ev_esubcode_s;
            pc_r         <= bus.wb_pc_in;
            badvaddr_r   <= ev_badvaddr_s;
            is_ertn_r    <= (ev_kind_s == EV_ERTN);
            wb_ex_r      <= (ev_kind_s == EV_EXC);
            ertn_flush_r <= (ev_kind_s == EV_ERTN);
            flush_r      <= 1'b1;
            wb_ready_r   <= 1'b0;
            state_r      <= ST_TRAP;
          end
        end
        ST_TRAP: begin
          wb_ex_r          <= 1'b0;
          ertn_flush_r     <= 1'b0;
          redirect_valid_r <= 1'b1;
          state_r          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_r <= 1'b0;
            cnt_r            <= DRAIN_INIT;
            state_r          <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_r == 4'd0) begin
            flush_r    <= 1'b0;
            wb_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          wb_ready_r       <= 1'b1;
          wb_ex_r          <= 1'b0;
          ertn_flush_r     <= 1'b0;
          flush_r          <= 1'b0;
          redirect_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_ready       = wb_ready_r;
  assign bus.wb_suppress    = commit_s && (ev_kind_s == EV_EXC);
  assign bus.wb_ex          = wb_ex_r;
  assign bus.ertn_flush     = ertn_flush_r;
  assign bus.flush          = flush_r;
  assign bus.wb_ecode       = ecode_r;
  assign bus.wb_esubcode    = esubcode_r;
  assign bus.WB_pc          = pc_r;
  assign bus.wb_badvaddr    = badvaddr_r;
  assign bus.redirect_valid = redirect_valid_r;
  // Target is read live: the CSR unit has settled ex_entry/ex_exit by REDIRECT
  assign bus.redirect_pc    = redirect_valid_r ? (is_ertn_r ? bus.ex_exit : bus.ex_entry) : '0;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed scenarios plus randomized
// commits compared against a priority/timeline model kept in the bench.
module tb_exc_commit_ctrl;

  localparam int DRAIN = 2;
  localparam int PCW   = 32;

  logic clk;
  logic resetn;
  int   vectors;
  int   miscompares;

  exc_commit_ctrl_if #(.PC_W(PCW)) bus ();

  exc_commit_ctrl #(.DRAIN_CYCLES(DRAIN), .PC_W(PCW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: kind 0 = none, 1 = exception/interrupt, 2 = ertn
  function automatic void model(input logic [4:0] f, input logic intr, input logic ertn,
                                input logic [31:0] pc, input logic [31:0] va,
                                output int kind, output logic [5:0] ec, output logic [31:0] bv);
    logic [5:0] code_of [5];
    code_of[4] = 6'h08;  // adef
    code_of[3] = 6'h0D;  // ine
    code_of[2] = 6'h0B;  // sys
    code_of[1] = 6'h0C;  // brk
    code_of[0] = 6'h09;  // ale
    kind = 0;
    ec   = 6'h00;
    bv   = 32'h0;
    if (intr) begin
      kind = 1;
    end else begin
      for (int b = 4; b >= 0; b--) begin
        if (f[b] && kind == 0) begin
          kind = 1;
          ec   = code_of[b];
          bv   = (b == 4) ? pc : ((b == 0) ? va : 32'h0);
        end
      end
      if (kind == 0 && ertn) kind = 2;
    end
  endfunction

  // One commit from IDLE through to the next IDLE cycle (or a reset abort)
  task automatic txn(input logic [4:0] f, input logic intr, input logic ertn,
                     input logic [31:0] pc, input logic [31:0] va,
                     input logic [31:0] entry, input logic [31:0] exitpc,
                     input int delay, input bit hold, input bit abort);
    int          kind;
    logic [5:0]  ec;
    logic [31:0] bv;
    logic [31:0] tgt;
    model(f, intr, ertn, pc, va, kind, ec, bv);
    tgt = (kind == 2) ? exitpc : entry;

    bus.wb_valid       = 1'b1;
    bus.wb_exc_flags   = f;
    bus.csr_has_int    = intr;
    bus.wb_is_ertn     = ertn;
    bus.wb_pc_in       = pc;
    bus.wb_vaddr_in    = va;
    bus.ex_entry       = entry;
    bus.ex_exit        = exitpc;
    bus.redirect_ready = 1'b0;
    #4;
    chk1("commit_wb_ready", bus.wb_ready, 1'b1);
    chk1("commit_suppress", bus.wb_suppress, kind == 1);
    next_cycle();
    if (!hold) begin
      bus.wb_valid    = 1'b0;
      bus.csr_has_int = 1'($urandom_range(0, 1));
    end

    if (kind == 0) begin
      #4;
      chk1("none_wb_ex", bus.wb_ex, 1'b0);
      chk1("none_flush", bus.flush, 1'b0);
      chk1("none_wb_ready", bus.wb_ready, 1'b1);
      chk1("none_redirect_valid", bus.redirect_valid, 1'b0);
      next_cycle();
      return;
    end

    #4;
    chk1("trap_wb_ex", bus.wb_ex, kind == 1);
    chk1("trap_ertn_flush", bus.ertn_flush, kind == 2);
    chk1("trap_flush", bus.flush, 1'b1);
    chk1("trap_redirect_valid", bus.redirect_valid, 1'b0);
    chk1("trap_wb_ready", bus.wb_ready, 1'b0);
    chk1("trap_suppress", bus.wb_suppress, 1'b0);
    if (kind == 1) begin
      chk("trap_ecode", 32'(bus.wb_ecode), 32'(ec));
      chk("trap_esubcode", 32'(bus.wb_esubcode), 32'h0);
      chk("trap_WB_pc", bus.WB_pc, pc);
      chk("trap_badvaddr", bus.wb_badvaddr, bv);
    end
    next_cycle();

    for (int i = 0; i <= delay; i++) begin
      bus.redirect_ready = (i == delay);
      if (abort && i == 1) resetn = 1'b0;
      #4;
      chk1("redir_valid", bus.redirect_valid, 1'b1);
      chk("redir_pc", bus.redirect_pc, tgt);
      chk1("redir_flush", bus.flush, 1'b1);
      chk1("redir_wb_ex", bus.wb_ex, 1'b0);
      chk1("redir_ertn_flush", bus.ertn_flush, 1'b0);
      chk1("redir_wb_ready", bus.wb_ready, 1'b0);
      chk1("redir_suppress", bus.wb_suppress, 1'b0);
      next_cycle();
      if (abort && i == 1) begin
        resetn             = 1'b1;
        bus.redirect_ready = 1'b0;
        bus.wb_valid       = 1'b0;
        #4;
        chk1("rst_redirect_valid", bus.redirect_valid, 1'b0);
        chk1("rst_flush", bus.flush, 1'b0);
        chk1("rst_wb_ready", bus.wb_ready, 1'b1);
        chk1("rst_wb_ex", bus.wb_ex, 1'b0);
        chk("rst_WB_pc", bus.WB_pc, 32'h0);
        next_cycle();
        return;
      end
    end

    for (int d = 0; d < DRAIN; d++) begin
      bus.redirect_ready = 1'($urandom_range(0, 1));
      #4;
      chk1("drain_flush", bus.flush, 1'b1);
      chk1("drain_redirect_valid", bus.redirect_valid, 1'b0);
      chk1("drain_wb_ready", bus.wb_ready, 1'b0);
      chk1("drain_wb_ex", bus.wb_ex, 1'b0);
      chk1("drain_ertn_flush", bus.ertn_flush, 1'b0);
      if (kind == 1) begin
        chk("drain_ecode_held", 32'(bus.wb_ecode), 32'(ec));
        chk("drain_WB_pc_held", bus.WB_pc, pc);
      end
      next_cycle();
    end
    bus.redirect_ready = 1'b0;
  endtask

  initial begin
    logic [4:0]  rf;
    logic [31:0] rpc;
    vectors            = 0;
    miscompares        = 0;
    resetn             = 1'b0;
    bus.wb_valid       = 1'b0;
    bus.wb_exc_flags   = 5'b00000;
    bus.csr_has_int    = 1'b0;
    bus.wb_is_ertn     = 1'b0;
    bus.wb_pc_in       = 32'h0;
    bus.wb_vaddr_in    = 32'h0;
    bus.ex_entry       = 32'h0;
    bus.ex_exit        = 32'h0;
    bus.redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #4;
    chk1("reset_wb_ready", bus.wb_ready, 1'b1);
    chk1("reset_flush", bus.flush, 1'b0);
    chk1("reset_wb_ex", bus.wb_ex, 1'b0);
    chk1("reset_ertn_flush", bus.ertn_flush, 1'b0);
    chk1("reset_redirect_valid", bus.redirect_valid, 1'b0);
    chk("reset_redirect_pc", bus.redirect_pc, 32'h0);
    chk("reset_WB_pc", bus.WB_pc, 32'h0);
    chk("reset_ecode", 32'(bus.wb_ecode), 32'h0);
    next_cycle();

    // sys, ready given in the first REDIRECT cycle
    txn(5'b00100, 1'b0, 1'b0, 32'h1c000100, 32'h0, 32'h1c008000, 32'h0, 0, 1'b0, 1'b0);
    // adef + ale: adef wins, badvaddr is the pc
    txn(5'b10001, 1'b0, 1'b0, 32'h1c000203, 32'h80000001, 32'h1c008000, 32'h0, 1, 1'b0, 1'b0);
    // interrupt masks ine
    txn(5'b01000, 1'b1, 1'b0, 32'h1c000040, 32'h0, 32'h1c008000, 32'h0, 0, 1'b0, 1'b0);
    // ertn with IF stalling the redirect for 3 cycles
    txn(5'b00000, 1'b0, 1'b1, 32'h1c000500, 32'h0, 32'h1c008000, 32'h1c000044, 3, 1'b0, 1'b0);
    // brk together with ertn: exception wins
    txn(5'b00010, 1'b0, 1'b1, 32'h1c000600, 32'h0, 32'h1c008000, 32'h1c000044, 0, 1'b0, 1'b0);
    // plain commit, no event
    txn(5'b00000, 1'b0, 1'b0, 32'h1c000700, 32'h0, 32'h1c008000, 32'h0, 0, 1'b0, 1'b0);
    // reset during REDIRECT, then an ale commit
    txn(5'b00100, 1'b0, 1'b0, 32'h1c000800, 32'h0, 32'h1c008000, 32'h0, 3, 1'b0, 1'b1);
    txn(5'b00001, 1'b0, 1'b0, 32'h1c000900, 32'h00001002, 32'h1c008000, 32'h0, 0, 1'b0, 1'b0);
    // back-to-back: wb_valid held with sys while busy
    txn(5'b00100, 1'b0, 1'b0, 32'h1c000a00, 32'h0, 32'h1c008000, 32'h0, 1, 1'b1, 1'b0);
    txn(5'b00100, 1'b0, 1'b0, 32'h1c000a00, 32'h0, 32'h1c008000, 32'h0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rf  = ($urandom_range(0, 2) == 0) ? 5'b00000 : 5'($urandom);
      rpc = $urandom & 32'hfffffffc;
      if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      txn(rf, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), rpc, $urandom,
          $urandom, $urandom, int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
